// File: rtl/ucaspian_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ucaspian_pkg
// Description : Shared types and default widths for the uCaspian axon stage.
// Revision    : 1.0 - initial release
// ============================================================================
package ucaspian_pkg;

    localparam int c_N_AXONS    = 256;
    localparam int c_DELAY_W    = 4;
    localparam int c_SYN_W      = 12;
    localparam int c_CNT_W      = 8;
    localparam int c_FIFO_DEPTH = 8;

    typedef struct packed {
        logic [c_DELAY_W-1:0] delay;
        logic [c_SYN_W-1:0]   first_syn;
        logic [c_CNT_W-1:0]   count;
    } axon_cfg_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SCAN  = 2'd2,
        DRAIN = 2'd3
    } axon_state_t;

endpackage
`default_nettype wire

// File: rtl/ucaspian_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ucaspian_fifo
// Description : Synchronous FIFO with first-word fall-through read data.
// Revision    : 1.0 - initial release
// ============================================================================
module ucaspian_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int c_PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW:0]    r_wp;
    logic [c_PW:0]    r_rp;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_wp[c_PW] != r_rp[c_PW]) && (r_wp[c_PW-1:0] == r_rp[c_PW-1:0]);
    assign empty  = (r_wp == r_rp);
    assign dout   = r_mem[r_rp[c_PW-1:0]];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp[c_PW-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/ucaspian_axon_gen.sv
`default_nettype none
// ============================================================================
// Module      : ucaspian_axon_gen
// Description : Axon stage; maps firing neurons to synapse ranges with delay.
// Revision    : 1.0 - initial release
// ============================================================================
module ucaspian_axon_gen
    import ucaspian_pkg::*;
#(
    parameter int N_AXONS    = c_N_AXONS,
    parameter int DELAY_W    = c_DELAY_W,
    parameter int SYN_W      = c_SYN_W,
    parameter int CNT_W      = c_CNT_W,
    parameter int FIFO_DEPTH = c_FIFO_DEPTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             clear_act,
    input  logic                             clear_config,
    output logic                             clear_done,
    input  logic [$clog2(N_AXONS)-1:0]       config_addr,
    input  logic [DELAY_W+SYN_W+CNT_W-1:0]   config_data,
    input  logic                             config_we,
    input  logic                             next_step,
    output logic                             step_done,
    output logic                             step_err,
    input  logic [$clog2(N_AXONS)-1:0]       axon_addr,
    input  logic                             axon_vld,
    output logic                             axon_rdy,
    output logic [SYN_W-1:0]                 syn_start,
    output logic [SYN_W-1:0]                 syn_end,
    output logic                             syn_vld,
    input  logic                             syn_rdy
);
    localparam int c_AW   = $clog2(N_AXONS);
    localparam int c_QW   = 2**DELAY_W;
    localparam int c_DWW  = c_QW + 1;
    localparam int c_CW   = DELAY_W + SYN_W + CNT_W;
    localparam logic [c_AW-1:0] c_LAST = c_AW'(N_AXONS - 1);

    axon_state_t       r_state, w_state_nxt;
    logic [c_AW-1:0]   r_idx, w_idx_nxt;
    logic              r_clr_cfg, r_clr_done, r_step_done, r_step_err, w_step_done_nxt;

    logic              w_fifo_full, w_fifo_empty, w_pop, w_scan_rd, w_rd_issue, w_rd_after;
    logic [c_AW-1:0]   w_fifo_dout, w_rd_addr;

    logic [c_CW-1:0]   r_cfg_mem [N_AXONS];
    logic [c_DWW-1:0]  r_dly_mem [N_AXONS];
    logic [c_CW-1:0]   r_cfg_rd, r_cfg_fwd_data, w_cfg, w_cfg_wdata;
    logic [c_DWW-1:0]  r_dly_rd, r_dly_fwd_data, w_dly, w_dly_wdata;
    logic              r_cfg_fwd, r_dly_fwd, w_cfg_we, w_dly_we;
    logic [c_AW-1:0]   w_cfg_waddr, w_dly_waddr;

    logic              r_s1_vld, r_s1_pop, r_s1_after;
    logic [c_AW-1:0]   r_s1_addr;

    logic              w_clear_req, w_stall, w_proc, w_hit, w_emit, w_sent_nxt;
    logic [DELAY_W-1:0] w_delay;
    logic [SYN_W-1:0]  w_first;
    logic [CNT_W-1:0]  w_count;
    logic [c_QW-1:0]   w_queue_nxt;

    logic              r_out_vld;
    logic [SYN_W-1:0]  r_out_start, r_out_end;

    ucaspian_fifo #(.WIDTH(c_AW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (axon_vld && !w_fifo_full),
        .din   (axon_addr),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // Read slot arbitration: queued fires win over the scan; nothing moves while stalled.
    assign w_clear_req = clear_act || clear_config;
    assign w_stall     = r_out_vld && !syn_rdy;
    assign w_pop       = !w_fifo_empty && !w_stall && (r_state != CLEAR)
                         && !((r_state == IDLE) && w_clear_req);
    assign w_scan_rd   = (r_state == SCAN) && w_fifo_empty && !w_stall;
    assign w_rd_issue  = w_pop || w_scan_rd;
    assign w_rd_addr   = w_pop ? w_fifo_dout : r_idx;
    assign w_rd_after  = ((r_state == SCAN) && (w_fifo_dout < r_idx)) || (r_state == DRAIN);

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_step_done_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_clear_req && !r_s1_vld) begin
                    w_state_nxt = CLEAR;
                    w_idx_nxt   = '0;
                end else if (!w_clear_req && next_step && enable) begin
                    w_state_nxt = SCAN;
                    w_idx_nxt   = '0;
                end
            end
            CLEAR: begin
                if (!w_clear_req)        w_state_nxt = IDLE;
                else if (r_idx != c_LAST) w_idx_nxt  = r_idx + 1'b1;
            end
            SCAN: begin
                if (w_scan_rd) begin
                    if (r_idx == c_LAST) w_state_nxt = DRAIN;
                    else                 w_idx_nxt   = r_idx + 1'b1;
                end
            end
            DRAIN: begin
                if (w_fifo_empty && !r_s1_vld && !r_out_vld) begin
                    w_state_nxt     = IDLE;
                    w_step_done_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_clr_cfg   <= 1'b0;
            r_clr_done  <= 1'b0;
            r_step_done <= 1'b0;
            r_step_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_step_done <= w_step_done_nxt;
            r_clr_done  <= (r_state == CLEAR) && w_clear_req && (r_idx == c_LAST);
            if (r_state == IDLE) r_clr_cfg <= clear_config;
            if (next_step && (r_state != IDLE)) r_step_err <= 1'b1;
        end
    end

    // Write ports: the clear sweep owns both RAMs; otherwise config port and stage-2 writeback.
    assign w_cfg_we    = (r_state == CLEAR) ? r_clr_cfg : config_we;
    assign w_cfg_waddr = (r_state == CLEAR) ? r_idx : config_addr;
    assign w_cfg_wdata = (r_state == CLEAR) ? '0 : config_data;
    assign w_dly_we    = (r_state == CLEAR) || w_proc;
    assign w_dly_waddr = (r_state == CLEAR) ? r_idx : r_s1_addr;
    assign w_dly_wdata = (r_state == CLEAR) ? '0 : {w_sent_nxt, w_queue_nxt};

    always_ff @(posedge clk) begin
        if (w_cfg_we)   r_cfg_mem[w_cfg_waddr] <= w_cfg_wdata;
        if (w_dly_we)   r_dly_mem[w_dly_waddr] <= w_dly_wdata;
        if (w_rd_issue) r_cfg_rd <= r_cfg_mem[w_rd_addr];
        if (w_rd_issue) r_dly_rd <= r_dly_mem[w_rd_addr];
    end

    // A read colliding with a same-edge write, or a write landing on a held read, is forwarded.
    always_ff @(posedge clk) begin
        if (w_rd_issue) begin
            r_cfg_fwd      <= w_cfg_we && (w_cfg_waddr == w_rd_addr);
            r_cfg_fwd_data <= w_cfg_wdata;
            r_dly_fwd      <= w_dly_we && (w_dly_waddr == w_rd_addr);
            r_dly_fwd_data <= w_dly_wdata;
        end else begin
            if (w_cfg_we && (w_cfg_waddr == r_s1_addr)) begin
                r_cfg_fwd      <= 1'b1;
                r_cfg_fwd_data <= w_cfg_wdata;
            end
            if (w_dly_we && (w_dly_waddr == r_s1_addr)) begin
                r_dly_fwd      <= 1'b1;
                r_dly_fwd_data <= w_dly_wdata;
            end
        end
    end

    assign w_cfg   = r_cfg_fwd ? r_cfg_fwd_data : r_cfg_rd;
    assign w_dly   = r_dly_fwd ? r_dly_fwd_data : r_dly_rd;
    assign w_delay = w_cfg[c_CW-1 -: DELAY_W];
    assign w_first = w_cfg[SYN_W+CNT_W-1 -: SYN_W];
    assign w_count = w_cfg[CNT_W-1:0];
    assign w_proc  = r_s1_vld && !w_stall;

    always_comb begin
        w_hit       = 1'b0;
        w_sent_nxt  = w_dly[c_QW];
        w_queue_nxt = w_dly[c_QW-1:0];
        if (r_s1_pop) begin
            if (w_delay == '0) begin
                if (!w_dly[c_QW]) begin
                    w_hit      = 1'b1;
                    w_sent_nxt = 1'b1;
                end
            end else if (r_s1_after) begin
                w_queue_nxt[w_delay - 1'b1] = 1'b1;
            end else begin
                w_queue_nxt[w_delay] = 1'b1;
            end
        end else begin
            w_sent_nxt  = 1'b0;
            w_hit       = w_dly[0];
            w_queue_nxt = w_dly[c_QW-1:0] >> 1;
        end
    end

    assign w_emit = w_proc && w_hit && (w_count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_vld    <= 1'b0;
            r_s1_pop    <= 1'b0;
            r_s1_after  <= 1'b0;
            r_s1_addr   <= '0;
            r_out_vld   <= 1'b0;
            r_out_start <= '0;
            r_out_end   <= '0;
        end else if (!w_stall) begin
            r_s1_vld   <= w_rd_issue;
            r_s1_pop   <= w_pop;
            r_s1_after <= w_rd_after;
            r_s1_addr  <= w_rd_addr;
            r_out_vld  <= w_emit;
            if (w_emit) begin
                r_out_start <= w_first;
                r_out_end   <= w_first + SYN_W'(w_count) - SYN_W'(1);
            end
        end
    end

    assign axon_rdy   = !w_fifo_full;
    assign syn_vld    = r_out_vld;
    assign syn_start  = r_out_start;
    assign syn_end    = r_out_end;
    assign step_done  = r_step_done;
    assign step_err   = r_step_err;
    assign clear_done = r_clr_done;

endmodule
`default_nettype wire
